bcm_scan_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 50 +++++
 rtl/bcm_on_timer.sv | 35 +++
 rtl/bcm_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bcm_scan_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED panel definitions: geometry, colour field
// offsets, scan FSM encoding and small helpers.
package led_pkg;

  localparam int LED_WIDTH     = 64;
  localparam int LED_ROWS_LOG2 = 5;
  localparam int LED_PLANES    = 8;

  localparam int R_OFS = 16;
  localparam int G_OFS = 8;
  localparam int B_OFS = 0;

  localparam int I_SHIFT   = 0;
  localparam int I_WAIT    = 1;
  localparam int I_BLANK   = 2;
  localparam int I_LATCH   = 3;
  localparam int I_UNLATCH = 4;
  localparam int I_UNBLANK = 5;

  typedef enum logic [5:0] {
    S_SHIFT   = 6'b000001,
    S_WAIT    = 6'b000010,
    S_BLANK   = 6'b000100,
    S_LATCH   = 6'b001000,
    S_UNLATCH = 6'b010000,
    S_UNBLANK = 6'b100000
  } scan_state_e;

  // {B,G,R} bit of plane p from a packed colour.
  function automatic logic [2:0] plane_bits(
    input logic [23:0] c,
    input logic [2:0]  p
  );
    logic [23:0] s;
    s = c >> p;
    return {s[B_OFS], s[G_OFS], s[R_OFS]};
  endfunction

  // The UNBLANK and BLANK cycles are part of the lit
  // window, so the timer only has to cover the rest.
  function automatic logic [15:0] on_load(
    input logic [7:0] base,
    input logic [2:0] p
  );
    logic [15:0] w;
    w = 16'(base) << p;
    return (w > 16'd2) ? w - 16'd2 : 16'd0;
  endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// Plane on-time down-counter: loads a weight, counts to
// zero every cycle and flags when it has expired.
module bcm_on_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Load wins over counting; otherwise decrement to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/bcm_scan_ctrl.sv
// BCM scan controller for a 64x64 HUB75 panel: shifts
// each bit-plane and weights its lit time by 2^plane.
module bcm_scan_ctrl
  import led_pkg::*;
#(
  parameter int WIDTH      = LED_WIDTH,
  parameter int ROWS_LOG2  = LED_ROWS_LOG2,
  parameter int PLANES     = LED_PLANES,
  parameter int BASE_TICKS = 1,
  parameter int PIX_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [6:0]           x,
  output logic [ROWS_LOG2-1:0] addr,
  output logic [12:0]          frame,
  input  logic [23:0]          rgb0,
  input  logic [23:0]          rgb1,
  output logic [2:0]           led_rgb0,
  output logic [2:0]           led_rgb1,
  output logic [ROWS_LOG2-1:0] led_addr,
  output logic                 led_blank,
  output logic                 led_latch,
  output logic                 sclk_ena
);

  localparam logic [7:0] SHIFT_LAST =
    8'(WIDTH + PIX_LAT - 1);

  scan_state_e state_q, state_d;

  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           plane_q, plane_d;
  logic [ROWS_LOG2-1:0] addr_q, addr_d;
  logic [12:0]          frame_q, frame_d;
  logic [2:0]           led_rgb0_q, led_rgb0_d;
  logic [2:0]           led_rgb1_q, led_rgb1_d;
  logic [ROWS_LOG2-1:0] led_addr_q, led_addr_d;
  logic                 led_blank_q, led_blank_d;
  logic                 led_latch_q, led_latch_d;
  logic                 sclk_ena_q, sclk_ena_d;

  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_zero;

  assign tmr_val = on_load(8'(BASE_TICKS), plane_q);

  bcm_on_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next state, pixel shift and panel strobe sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    plane_d     = plane_q;
    addr_d      = addr_q;
    frame_d     = frame_q;
    led_rgb0_d  = led_rgb0_q;
    led_rgb1_d  = led_rgb1_q;
    led_addr_d  = led_addr_q;
    led_blank_d = led_blank_q;
    led_latch_d = led_latch_q;
    sclk_ena_d  = 1'b0;
    tmr_load    = 1'b0;
    unique case (1'b1)
      state_q[I_SHIFT]: begin
        cnt_d = cnt_q + 8'd1;
        // rgb now carries pixel cnt_q - PIX_LAT
        if (cnt_q >= 8'(PIX_LAT)) begin
          led_rgb0_d = plane_bits(rgb0, plane_q);
          led_rgb1_d = plane_bits(rgb1, plane_q);
          sclk_ena_d = 1'b1;
        end
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      state_q[I_WAIT]: begin
        if (tmr_zero) begin
          state_d = S_BLANK;
        end
      end
      state_q[I_BLANK]: begin
        led_blank_d = 1'b1;
        led_addr_d  = addr_q;
        state_d     = S_LATCH;
      end
      state_q[I_LATCH]: begin
        led_latch_d = 1'b1;
        state_d     = S_UNLATCH;
      end
      state_q[I_UNLATCH]: begin
        led_latch_d = 1'b0;
        state_d     = S_UNBLANK;
      end
      state_q[I_UNBLANK]: begin
        led_blank_d = 1'b0;
        tmr_load    = 1'b1;
        if (plane_q == 3'(PLANES - 1)) begin
          plane_d = 3'd0;
          addr_d  = addr_q + 1'b1;
          if (addr_q == '1) begin
            frame_d = frame_q + 13'd1;
          end
        end else begin
          plane_d = plane_q + 3'd1;
        end
        state_d = S_SHIFT;
      end
      default: begin
        state_d = S_SHIFT;
      end
    endcase
  end

  // State and output registers; outputs dark on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_SHIFT;
      cnt_q       <= 8'd0;
      plane_q     <= 3'd0;
      addr_q      <= '0;
      frame_q     <= 13'd0;
      led_rgb0_q  <= 3'd0;
      led_rgb1_q  <= 3'd0;
      led_addr_q  <= '0;
      led_blank_q <= 1'b1;
      led_latch_q <= 1'b0;
      sclk_ena_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      plane_q     <= plane_d;
      addr_q      <= addr_d;
      frame_q     <= frame_d;
      led_rgb0_q  <= led_rgb0_d;
      led_rgb1_q  <= led_rgb1_d;
      led_addr_q  <= led_addr_d;
      led_blank_q <= led_blank_d;
      led_latch_q <= led_latch_d;
      sclk_ena_q  <= sclk_ena_d;
    end
  end

  assign x = (cnt_q < 8'(WIDTH)) ? cnt_q[6:0] : 7'd0;

  assign addr      = addr_q;
  assign frame     = frame_q;
  assign led_rgb0  = led_rgb0_q;
  assign led_rgb1  = led_rgb1_q;
  assign led_addr  = led_addr_q;
  assign led_blank = led_blank_q;
  assign led_latch = led_latch_q;
  assign sclk_ena  = sclk_ena_q;

endmodule

// File: tb/tb_bcm_scan_ctrl.sv
// Directed bench for bcm_scan_ctrl with a one-cycle
// stub painter; BASE_TICKS=2, PIX_LAT=1.
module tb_bcm_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode = 1'b0;
  logic [6:0]  x;
  logic [4:0]  addr;
  logic [12:0] frame;
  logic [23:0] rgb0 = 24'd0;
  logic [23:0] rgb1 = 24'd0;
  logic [2:0]  led_rgb0;
  logic [2:0]  led_rgb1;
  logic [4:0]  led_addr;
  logic        led_blank;
  logic        led_latch;
  logic        sclk_ena;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcm_scan_ctrl #(
    .WIDTH      (64),
    .ROWS_LOG2  (5),
    .PLANES     (8),
    .BASE_TICKS (2),
    .PIX_LAT    (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .addr      (addr),
    .frame     (frame),
    .rgb0      (rgb0),
    .rgb1      (rgb1),
    .led_rgb0  (led_rgb0),
    .led_rgb1  (led_rgb1),
    .led_addr  (led_addr),
    .led_blank (led_blank),
    .led_latch (led_latch),
    .sclk_ena  (sclk_ena)
  );

  // R = x, G = ~x, B = x>>1
  function automatic logic [23:0] pat(input logic [6:0] px);
    logic [7:0] v;
    v = {1'b0, px};
    return {v, ~v, v >> 1};
  endfunction

  // {B,G,R} bit of plane p
  function automatic logic [2:0] exp_bits(
    input logic [23:0] c,
    input int p
  );
    return {c[p], c[8+p], c[16+p]};
  endfunction

  // Stub painter with one clock of latency.
  always @(posedge clk) begin
    rgb0 <= mode ? 24'h804001 : pat(x);
    rgb1 <= mode ? pat(x) : 24'h804001;
  end

  task automatic test_reset();
    mode = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (led_blank !== 1'b1) begin
      fails++;
      $display("FAIL reset_blank got %b want 1", led_blank);
    end
    tests++;
    if (led_latch !== 1'b0) begin
      fails++;
      $display("FAIL reset_latch got %b want 0", led_latch);
    end
    tests++;
    if (sclk_ena !== 1'b0) begin
      fails++;
      $display("FAIL reset_sclk got %b want 0", sclk_ena);
    end
    tests++;
    if (frame !== 13'd0) begin
      fails++;
      $display("FAIL reset_frame got %0d want 0", frame);
    end
    tests++;
    if (addr !== 5'd0 || led_addr !== 5'd0) begin
      fails++;
      $display("FAIL reset_addr got %0d/%0d want 0/0",
               addr, led_addr);
    end
    tests++;
    if (x !== 7'd0 || led_rgb0 !== 3'd0) begin
      fails++;
      $display("FAIL reset_x_rgb got %0d/%b want 0/000",
               x, led_rgb0);
    end
    reset_n = 1'b1;
  endtask

  // Samples 1..66 after release: plane 0 of row 0.
  task automatic test_shift();
    int highs = 0;
    int first = -1;
    int bad = 0;
    int k = 0;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (sclk_ena === 1'b1) begin
        if (first < 0) first = i;
        if (led_rgb0 !== exp_bits(pat(7'(k)), 0)) bad++;
        if (led_rgb1 !== 3'b100) bad++;
        k++;
        highs++;
      end
    end
    tests++;
    if (highs !== 64) begin
      fails++;
      $display("FAIL shift_count got %0d want 64", highs);
    end
    tests++;
    if (first !== 2) begin
      fails++;
      $display("FAIL shift_first got %0d want 2", first);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL shift_data got %0d bad want 0", bad);
    end
  endtask

  // Samples 67..70: latch strobe and unblank.
  task automatic test_latch();
    @(negedge clk);
    tests++;
    if (led_latch !== 1'b0 || led_blank !== 1'b1) begin
      fails++;
      $display("FAIL pre_latch got %b%b want 01",
               led_latch, led_blank);
    end
    @(negedge clk);
    tests++;
    if (led_latch !== 1'b1 || led_blank !== 1'b1) begin
      fails++;
      $display("FAIL latch_pulse got %b%b want 11",
               led_latch, led_blank);
    end
    tests++;
    if (led_addr !== 5'd0) begin
      fails++;
      $display("FAIL latch_addr got %0d want 0", led_addr);
    end
    @(negedge clk);
    tests++;
    if (led_latch !== 1'b0 || led_blank !== 1'b1) begin
      fails++;
      $display("FAIL post_latch got %b%b want 01",
               led_latch, led_blank);
    end
    @(negedge clk);
    tests++;
    if (led_blank !== 1'b0) begin
      fails++;
      $display("FAIL unblank got %b want 0", led_blank);
    end
  endtask

  // Blank-low windows for row 0 planes 0..7.
  task automatic test_on_time();
    int want[8] = '{67, 67, 67, 67, 67, 67, 128, 256};
    int viol = 0;
    for (int r = 0; r < 8; r++) begin
      int n = 0;
      int g = 0;
      while (led_blank !== 1'b0 && g < 1000) begin
        @(negedge clk);
        g++;
        if (led_latch === 1'b1 && led_blank !== 1'b1) viol++;
      end
      while (led_blank === 1'b0 && n < 1000) begin
        n++;
        @(negedge clk);
        if (led_latch === 1'b1 && led_blank !== 1'b1) viol++;
      end
      tests++;
      if (n !== want[r]) begin
        fails++;
        $display("FAIL window_p%0d got %0d want %0d",
                 r, n, want[r]);
      end
    end
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL latch_lit got %0d want 0", viol);
    end
    tests++;
    if (addr !== 5'd1) begin
      fails++;
      $display("FAIL row_advance got %0d want 1", addr);
    end
    tests++;
    if (led_addr !== 5'd1) begin
      fails++;
      $display("FAIL led_addr_row1 got %0d want 1", led_addr);
    end
  endtask

  task automatic test_frame();
    int n = 0;
    int changes = 0;
    logic [4:0] prev;
    prev = addr;
    while (frame === 13'd0 && n < 30000) begin
      @(negedge clk);
      n++;
      if (addr !== prev) begin
        changes++;
        prev = addr;
      end
    end
    tests++;
    if (frame !== 13'd1) begin
      fails++;
      $display("FAIL frame_inc got %0d want 1", frame);
    end
    tests++;
    if (addr !== 5'd0) begin
      fails++;
      $display("FAIL frame_addr got %0d want 0", addr);
    end
    tests++;
    if (led_addr !== 5'd31) begin
      fails++;
      $display("FAIL frame_led_addr got %0d want 31",
               led_addr);
    end
    tests++;
    if (changes !== 31) begin
      fails++;
      $display("FAIL frame_rows got %0d want 31", changes);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    dut.frame_q = 13'd8191;
    #1;
    while (frame === 13'd8191 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (frame !== 13'd0) begin
      fails++;
      $display("FAIL frame_wrap got %0d want 0", frame);
    end
    tests++;
    if (addr !== 5'd0) begin
      fails++;
      $display("FAIL wrap_addr got %0d want 0", addr);
    end
  endtask

  task automatic test_reset_pulse();
    int n = 0;
    while (addr !== 5'd2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (led_latch !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (led_latch !== 1'b1 || led_addr !== 5'd2) begin
      fails++;
      $display("FAIL pulse_setup got %b/%0d want 1/2",
               led_latch, led_addr);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (led_latch !== 1'b0 || led_blank !== 1'b1) begin
      fails++;
      $display("FAIL pulse_dark got %b%b want 01",
               led_latch, led_blank);
    end
    tests++;
    if (addr !== 5'd0 || led_addr !== 5'd0) begin
      fails++;
      $display("FAIL pulse_addr got %0d/%0d want 0/0",
               addr, led_addr);
    end
    tests++;
    if (sclk_ena !== 1'b0 || x !== 7'd0) begin
      fails++;
      $display("FAIL pulse_sclk got %b/%0d want 0/0",
               sclk_ena, x);
    end
    @(negedge clk);
    mode = 1'b1;
    reset_n = 1'b1;
  endtask

  // rgb0 = 804001 across planes 0..7 after restart.
  task automatic test_slicing();
    logic [2:0] w0[8] = '{3'b100, 3'b000, 3'b000, 3'b000,
                          3'b000, 3'b000, 3'b010, 3'b001};
    int bad[8];
    int hi[8];
    int pl = -1;
    int k = 0;
    int n = 0;
    logic prev = 1'b0;
    for (int p = 0; p < 8; p++) begin
      bad[p] = 0;
      hi[p] = 0;
    end
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (sclk_ena === 1'b1 && prev !== 1'b1) begin
        pl++;
        k = 0;
      end
      prev = sclk_ena;
      if (pl >= 8) break;
      if (sclk_ena === 1'b1 && pl >= 0) begin
        hi[pl]++;
        if (led_rgb0 !== w0[pl]) bad[pl]++;
        if (led_rgb1 !== exp_bits(pat(7'(k)), pl))
          bad[pl]++;
        k++;
      end
    end
    tests++;
    if (pl !== 8) begin
      fails++;
      $display("FAIL slice_planes got %0d want 8", pl);
    end
    for (int p = 0; p < 8; p++) begin
      tests++;
      if (hi[p] !== 64 || bad[p] !== 0) begin
        fails++;
        $display("FAIL slice_p%0d got %0d/%0d want 64/0",
                 p, hi[p], bad[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_latch();
    test_on_time();
    test_frame();
    test_wrap();
    test_reset_pulse();
    test_slicing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
